// File: rtl/i2s_pkg.sv
// Shared constants, state encoding and sizing helper for the I2S transmitter.
package i2s_pkg;

    localparam logic I2S_FMT_I2S = 1'b0;
    localparam logic I2S_FMT_LJ  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // Counter = bclk phase bits (half-period plus bclk level) above which sits the frame bit index.
    function automatic int cnt_width(input int div_log2, input int slot_w);
        return div_log2 + 1 + $clog2(2 * slot_w);
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Show-ahead synchronous frame FIFO with occupancy count; head word is always on rd_data.
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is reset so an underrun-free start never serialises X; depth is tiny.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified serial transmitter with bclk/ws generator and frame FIFO.
// Define I2S_TX_HOLD_LAST_EN to repeat the last popped frame on underrun instead of silence.
module i2s_tx_stereo
    import i2s_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int SLOT_W        = 16,
    parameter int BCLK_DIV_LOG2 = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        en_in,
    input  logic                        fmt_in,
    input  logic [DATA_W-1:0]           left_in,
    input  logic [DATA_W-1:0]           right_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic                        clr_underrun_in,
    output logic [$clog2(FIFO_DEPTH):0] level_out,
    output logic                        underrun_out,
    output logic                        d_out,
    output logic                        ws_out,
    output logic                        bclk_out
);

    localparam int CNT_W   = cnt_width(BCLK_DIV_LOG2, SLOT_W);
    localparam int LOW_W   = BCLK_DIV_LOG2 + 1;
    localparam int FB_W    = CNT_W - LOW_W;
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int PAIR_W  = 2 * DATA_W;

    tx_state_e          state;
    tx_state_e          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [FRAME_W-1:0] shift;
    logic [FRAME_W-1:0] shift_nxt;
    logic [FRAME_W-1:0] load_word;
    logic               delay_bit;
    logic               delay_nxt;
    logic               fmt_lj;
    logic               fmt_nxt;
    logic [FB_W-1:0]    fb;
    logic               bit_end;
    logic               terminal;
    logic               frame_start;
    logic [PAIR_W-1:0]  fifo_rd;
    logic [PAIR_W-1:0]  fill_pair;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               underrun_set;

    // Places each sample at the top of its slot; the low SLOT_W-DATA_W bits stay zero.
    function automatic logic [FRAME_W-1:0] to_frame(input logic [PAIR_W-1:0] pair);
        logic [FRAME_W-1:0] l_word;
        logic [FRAME_W-1:0] r_word;
        l_word = FRAME_W'(pair[PAIR_W-1:DATA_W]);
        r_word = FRAME_W'(pair[DATA_W-1:0]);
        return (l_word << (FRAME_W - DATA_W)) | (r_word << (SLOT_W - DATA_W));
    endfunction

    assign fifo_push    = valid_in && !fifo_full;
    assign fifo_pop     = frame_start && !fifo_empty;
    assign underrun_set = frame_start && fifo_empty;
    assign ready_out    = !fifo_full;

    i2s_frame_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst_n   (reset_in),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({left_in, right_in}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level_out)
    );

`ifdef I2S_TX_HOLD_LAST_EN
    logic [PAIR_W-1:0] last_pair;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            last_pair <= '0;
        end else if (fifo_pop) begin
            last_pair <= fifo_rd;
        end
    end

    assign fill_pair = last_pair;
`else
    assign fill_pair = '0;
`endif

    assign fb          = cnt[CNT_W-1:LOW_W];
    assign bit_end     = &cnt[LOW_W-1:0];
    assign terminal    = bit_end && (fb == FB_W'(FRAME_W - 1));
    assign frame_start = en_in && ((state == ST_IDLE) || terminal);
    assign load_word   = to_frame(fifo_empty ? fill_pair : fifo_rd);

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift;
        delay_nxt = delay_bit;
        fmt_nxt   = fmt_lj;
        if (!en_in) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            shift_nxt = '0;
            delay_nxt = 1'b0;
        end else if (state == ST_IDLE) begin
            state_nxt = ST_RUN;
            fmt_nxt   = fmt_in;
            cnt_nxt   = '0;
            shift_nxt = load_word;
            delay_nxt = 1'b0;
        end else if (terminal) begin
            // The outgoing frame's last bit moves into the I2S delay stage for fb 0.
            cnt_nxt   = '0;
            shift_nxt = load_word;
            delay_nxt = shift[FRAME_W-1];
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
            if (bit_end) begin
                shift_nxt = shift << 1;
                delay_nxt = shift[FRAME_W-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            shift        <= '0;
            delay_bit    <= 1'b0;
            fmt_lj       <= I2S_FMT_I2S;
            bclk_out     <= 1'b0;
            ws_out       <= 1'b0;
            d_out        <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift     <= shift_nxt;
            delay_bit <= delay_nxt;
            fmt_lj    <= fmt_nxt;
            bclk_out  <= cnt_nxt[BCLK_DIV_LOG2];
            ws_out    <= (cnt_nxt[CNT_W-1:LOW_W] >= FB_W'(SLOT_W));
            d_out     <= (fmt_nxt == I2S_FMT_LJ) ? shift_nxt[FRAME_W-1] : delay_nxt;
            if (underrun_set) begin
                underrun_out <= 1'b1;
            end else if (clr_underrun_in) begin
                underrun_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Self-checking bench for i2s_tx_stereo: frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_i2s_tx_stereo;
    import i2s_pkg::*;

    localparam int DATA_W     = 16;
    localparam int SLOT_W     = 16;
    localparam int DIV        = 4;
    localparam int DEPTH      = 4;
    localparam int LVL_W      = $clog2(DEPTH) + 1;
    localparam int HALF       = 1 << DIV;
    localparam int BIT_CLKS   = 2 * HALF;
    localparam int FRAME_W    = 2 * SLOT_W;
    localparam int FRAME_CLKS = FRAME_W * BIT_CLKS;

`ifdef I2S_TX_HOLD_LAST_EN
    localparam logic [31:0] FILL_WORD = {16'hB332, 16'h4003};
`else
    localparam logic [31:0] FILL_WORD = 32'h0000_0000;
`endif

    typedef logic [FRAME_W-1:0] frame_t;

    logic clk = 1'b0;
    logic reset_in = 1'b1;

    logic              en, fmt, valid, clr;
    logic [DATA_W-1:0] left, right;
    logic              ready, underrun, d, ws, bclk;
    logic [LVL_W-1:0]  level;

    logic        p_en, p_fmt, p_valid, p_clr;
    logic [11:0] p_left, p_right;
    logic        p_ready, p_underrun, p_d, p_ws, p_bclk;
    logic [2:0]  p_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2s_tx_stereo #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV_LOG2(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk), .reset_in(reset_in), .en_in(en), .fmt_in(fmt),
        .left_in(left), .right_in(right), .valid_in(valid), .ready_out(ready),
        .clr_underrun_in(clr), .level_out(level), .underrun_out(underrun),
        .d_out(d), .ws_out(ws), .bclk_out(bclk)
    );

    i2s_tx_stereo #(.DATA_W(12), .SLOT_W(24), .BCLK_DIV_LOG2(1), .FIFO_DEPTH(4)) dut_pad (
        .clk_in(clk), .reset_in(reset_in), .en_in(p_en), .fmt_in(p_fmt),
        .left_in(p_left), .right_in(p_right), .valid_in(p_valid), .ready_out(p_ready),
        .clr_underrun_in(p_clr), .level_out(p_level), .underrun_out(p_underrun),
        .d_out(p_d), .ws_out(p_ws), .bclk_out(p_bclk)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame queue and position within the frame ----------------
    frame_t q[$];
    bit     m_run = 1'b0;
    int     m_k = 0;
    frame_t m_word = '0;
    bit     m_prev = 1'b0;
    bit     m_fmt = 1'b0;
    bit     m_underrun = 1'b0;
    frame_t m_last = '0;

    function automatic frame_t pack(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        frame_t w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w[FRAME_W-1-i] = l[DATA_W-1-i];
            w[SLOT_W-1-i]  = r[DATA_W-1-i];
        end
        return w;
    endfunction

    always @(posedge clk or negedge reset_in) begin
        bit do_push, start, set;
        if (!reset_in) begin
            q.delete();
            m_run = 1'b0; m_k = 0; m_word = '0; m_prev = 1'b0;
            m_fmt = 1'b0; m_underrun = 1'b0; m_last = '0;
        end else begin
            do_push = valid && (q.size() < DEPTH);
            start   = en && (!m_run || m_k == FRAME_CLKS - 1);
            set     = 1'b0;
            if (!en) begin
                m_run = 1'b0; m_k = 0; m_word = '0; m_prev = 1'b0;
            end else if (start) begin
                m_prev = m_run ? m_word[0] : 1'b0;
                if (!m_run) m_fmt = fmt;
                if (q.size() == 0) begin
                    set = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                    m_word = m_last;
`else
                    m_word = '0;
`endif
                end else begin
                    m_word = q.pop_front();
                    m_last = m_word;
                end
                m_run = 1'b1;
                m_k   = 0;
            end else begin
                m_k++;
            end
            if (do_push) q.push_back(pack(left, right));
            if (set) m_underrun = 1'b1;
            else if (clr) m_underrun = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic e_bclk, e_ws, e_d;
        int fb;
        e_bclk = 1'b0; e_ws = 1'b0; e_d = 1'b0;
        if (m_run) begin
            fb     = m_k / BIT_CLKS;
            e_bclk = ((m_k / HALF) % 2) == 1;
            e_ws   = fb >= SLOT_W;
            if (m_fmt) e_d = m_word[FRAME_W-1-fb];
            else       e_d = (fb == 0) ? m_prev : m_word[FRAME_W-fb];
        end
        check("cycle {ready,level,underrun,d,ws,bclk}",
              {ready, level, underrun, d, ws, bclk},
              {q.size() < DEPTH, LVL_W'(q.size()), m_underrun, e_d, e_ws, e_bclk});
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        left = l; right = r; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Steps clocks until the chosen instance's bclk rises; waited = -1 if the budget expires.
    task automatic wait_rise(input bit pad, output bit d_s, output bit ws_s, output int waited);
        bit prev, cur;
        waited = 0;
        d_s = 1'b0; ws_s = 1'b0;
        prev = pad ? p_bclk : bclk;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            waited++;
            cur = pad ? p_bclk : bclk;
            if (cur && !prev) begin
                d_s  = pad ? p_d : d;
                ws_s = pad ? p_ws : ws;
                return;
            end
            prev = cur;
        end
        waited = -1;
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit d_s, ws_s;
        int waited, highs, total;
        logic [31:0] cap32, ws32;
        logic [32:0] cap33;
        logic [47:0] cap48, ws48;
        logic [DATA_W-1:0] lefts [5];
        lefts = '{16'h8001, 16'h9110, 16'hA223, 16'hB332, 16'hC445};

        en = 1'b0; fmt = I2S_FMT_LJ; valid = 1'b0; clr = 1'b0; left = '0; right = '0;
        p_en = 1'b0; p_fmt = I2S_FMT_LJ; p_valid = 1'b0; p_clr = 1'b0; p_left = '0; p_right = '0;

        #1 reset_in = 1'b0;
        #2;
        check("rst_ready", ready, 1);
        check("rst_level", level, 0);
        check("rst_outputs {underrun,d,ws,bclk}", {underrun, d, ws, bclk}, 4'b0000);
        repeat (3) @(posedge clk);
        #1 reset_in = 1'b1;

        // Idle: bclk must stay parked.
        highs = 0;
        repeat (2000) begin
            @(posedge clk); #1;
            if (bclk) highs++;
        end
        check("idle_bclk_high_cycles", highs, 0);

        // Left-justified, default parameters.
        push_frame(16'hA5C3, 16'h0F01);
        check("lj_push_level", level, 1);
        fmt = I2S_FMT_LJ; en = 1'b1;
        for (int j = 0; j < 32; j++) begin
            wait_rise(1'b0, d_s, ws_s, waited);
            if (j == 0) check("lj_en_to_bclk", waited, HALF + 1);
            else        check("lj_bit_period", waited, BIT_CLKS);
            cap32[31-j] = d_s;
            ws32[31-j]  = ws_s;
        end
        en = 1'b0;
        check("lj_left", cap32[31:16], 16'hA5C3);
        check("lj_right", cap32[15:0], 16'h0F01);
        check("lj_ws", ws32, 32'h0000_FFFF);

        // I2S: one-bclk data delay, right LSB lands in fb 0 of the next frame.
        @(posedge clk); #1;
        push_frame(16'hA5C3, 16'h0F01);
        push_frame(16'h1234, 16'h5678);
        push_frame(16'h0000, 16'hFFFF);
        fmt = I2S_FMT_I2S; en = 1'b1;
        for (int j = 0; j < 33; j++) begin
            wait_rise(1'b0, d_s, ws_s, waited);
            if (j > 0) check("i2s_bit_period", waited, BIT_CLKS);
            cap33[32-j] = d_s;
        end
        check("i2s_first_bit", cap33[32], 0);
        check("i2s_left", cap33[31:16], 16'hA5C3);
        check("i2s_right_incl_next_fb0", cap33[15:0], 16'h0F01);
        check("pre_reset_level", level, 1);

        // Reset asserted while running.
        reset_in = 1'b0;
        #1;
        check("midrun_rst_ready", ready, 1);
        check("midrun_rst_level", level, 0);
        check("midrun_rst_outputs {underrun,d,ws,bclk}", {underrun, d, ws, bclk}, 4'b0000);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_in = 1'b1;

        // FIFO full, then drain one frame per frame period into an underrun.
        for (int i = 0; i < 5; i++) begin
            left = lefts[i]; right = 16'h4000 + 16'(i); valid = 1'b1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        check("full_ready", ready, 0);
        check("full_level", level, 4);
        fmt = I2S_FMT_LJ; en = 1'b1;
        @(posedge clk); #1;
        check("first_pop_ready", ready, 1);
        check("first_pop_level", level, 3);
        waited = 0;
        for (int i = 0; i < 6 * FRAME_CLKS && !underrun; i++) begin
            @(posedge clk); #1;
            waited++;
        end
        check("underrun_after_4_frames", waited, 4 * FRAME_CLKS);
        check("underrun_level", level, 0);

        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_underrun", underrun, 0);
        for (int i = 0; i < FRAME_CLKS + 4 && m_k != FRAME_CLKS - 1; i++) begin
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("set_beats_clr", underrun, 1);
        for (int j = 0; j < 32; j++) begin
            wait_rise(1'b0, d_s, ws_s, waited);
            if (j > 0) check("fill_bit_period", waited, BIT_CLKS);
            cap32[31-j] = d_s;
        end
        check("fill_frame", cap32, FILL_WORD);
        en = 1'b0;
        @(posedge clk); #1;

        // Padded slots: DATA_W=12, SLOT_W=24, BCLK_DIV_LOG2=1.
        p_left = 12'hABC; p_right = 12'h123; p_valid = 1'b1;
        @(posedge clk); #1;
        p_valid = 1'b0;
        check("pad_level", p_level, 1);
        p_fmt = I2S_FMT_LJ; p_en = 1'b1;
        total = 0;
        for (int j = 0; j < 49; j++) begin
            wait_rise(1'b1, d_s, ws_s, waited);
            if (j == 0) begin
                check("pad_en_to_bclk", waited, 3);
            end else begin
                check("pad_bit_period", waited, 4);
                total += waited;
            end
            if (j < 48) begin
                cap48[47-j] = d_s;
                ws48[47-j]  = ws_s;
            end else begin
                check("pad_next_frame_ws", ws_s, 0);
            end
        end
        p_en = 1'b0;
        check("pad_frame", cap48, {12'hABC, 12'h000, 12'h123, 12'h000});
        check("pad_ws", ws48, 48'h000000_FFFFFF);
        check("pad_frame_clks", total, 192);
        check("pad_underrun", p_underrun, 1);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
